mod_instr_fetch: RTL and testbench

//  Instruction fetch stage; sits directly upstream of the instruction decode stage.
//  - Owns the program counter and issues in-order word requests to instruction memory.
//  - Buffers returned words in a FIFO, then presents {instr, pc} to decode over valid/ready.
//  - Handles control-flow redirects (branch/jump/JALR target) by flushing buffered and
//    in-flight fetches.

---
 rtl/mod_instr_fetch.sv | 183 ++++++++++++++++++
 tb/tb_mod_instr_fetch.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_instr_fetch.sv
// Instruction fetch: PC owner, in-order imem requests, buffered {instr, pc} to decode; FETCH_MISALIGN_TRAP_EN adds the misaligned-redirect trap.
// Latency: rvalid -> instr_valid_o one cycle (FIFO head is a register); first request two cycles after reset release.
// Backpressure: requests stop once in-flight plus buffered words would exceed FIFO_DEPTH; decode stalls hold the head.
`ifndef XLEN
`define XLEN 32
`endif

module mod_instr_fetch_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic                   push_vld,
  input  logic [W-1:0]           push_dat,
  input  logic                   pop_rdy,
  output logic [W-1:0]           pop_dat,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop_rdy && (count != '0);
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_vld) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push_vld) - (AW+1)'(do_pop);
    end
  end

  // A full FIFO may only accept a word in the same cycle it releases one.
  no_overflow: assert property (@(posedge clk_i) disable iff (rst_i || flush_i)
    !(push_vld && full && !do_pop));
endmodule

module mod_instr_fetch #(
  parameter logic [`XLEN-1:0] RESET_PC   = '0,
  parameter int               FIFO_DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  output logic             imem_req_o,
  output logic [`XLEN-1:0] imem_addr_o,
  input  logic             imem_gnt_i,
  input  logic             imem_rvalid_i,
  input  logic [`XLEN-1:0] imem_rdata_i,
  input  logic             redirect_i,
  input  logic [`XLEN-1:0] redirect_pc_i,
  output logic             instr_valid_o,
  input  logic             instr_ready_i,
  output logic [`XLEN-1:0] instr_o,
  output logic [`XLEN-1:0] instr_pc_o,
  output logic             misalign_o
);
  localparam int XLEN = `XLEN;
  localparam int CW   = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [1:0] {S_BOOT, S_FETCH, S_HALT} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [CW-1:0]   discard_q, discard_d;
  logic            misalign_q, misalign_d;

  logic            grant;
  logic            drop;
  logic            push;
  logic            pop;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   outstanding_next;
  logic [CW-1:0]   fifo_count;
  logic [CW:0]     credit_used;
  logic            credit_ok;
  logic [XLEN-1:0] rsp_pc;

  assign grant = imem_req_o && imem_gnt_i;
  assign drop  = imem_rvalid_i && (redirect_i || (discard_q != '0));
  assign push  = imem_rvalid_i && !drop;
  assign pop   = instr_valid_o && instr_ready_i;

  assign outstanding_next = outstanding + CW'(grant) - CW'(imem_rvalid_i);

  // Occupancy is taken net of this cycle's pop so a streaming decode sustains one word per cycle.
  assign credit_used = {1'b0, outstanding} + {1'b0, fifo_count} - (CW+1)'(pop);
  assign credit_ok   = credit_used < (CW+1)'(FIFO_DEPTH);

  // In-flight request PCs; responses return in order, so occupancy is the outstanding count.
  mod_instr_fetch_fifo #(.W(XLEN), .DEPTH(FIFO_DEPTH)) u_tag_fifo (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .flush_i  (1'b0),
    .push_vld (grant),
    .push_dat (pc_q),
    .pop_rdy  (imem_rvalid_i),
    .pop_dat  (rsp_pc),
    .count    (outstanding)
  );

  mod_instr_fetch_fifo #(.W(2*XLEN), .DEPTH(FIFO_DEPTH)) u_instr_fifo (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .flush_i  (redirect_i),
    .push_vld (push),
    .push_dat ({imem_rdata_i, rsp_pc}),
    .pop_rdy  (pop),
    .pop_dat  ({instr_o, instr_pc_o}),
    .count    (fifo_count)
  );

  assign instr_valid_o = (fifo_count != '0);
  assign imem_addr_o   = pc_q;
  assign misalign_o    = misalign_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    discard_d  = discard_q;
    misalign_d = misalign_q;
    imem_req_o = 1'b0;

    case (state_q)
      S_BOOT:  state_d = S_FETCH;
      S_FETCH: imem_req_o = !redirect_i && credit_ok;
      S_HALT:  imem_req_o = 1'b0;
      default: state_d = S_BOOT;
    endcase

    if (grant) pc_d = pc_q + XLEN'(4);
    if (imem_rvalid_i && (discard_q != '0)) discard_d = discard_q - CW'(1);

    if (redirect_i) begin
      pc_d      = redirect_pc_i & ~XLEN'(3);
      discard_d = outstanding_next;
`ifdef FETCH_MISALIGN_TRAP_EN
      if (redirect_pc_i[1:0] != 2'b00) begin
        state_d    = S_HALT;
        misalign_d = 1'b1;
      end else begin
        state_d    = S_FETCH;
        misalign_d = 1'b0;
      end
`else
      state_d = S_FETCH;
`endif
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_BOOT;
      pc_q       <= RESET_PC;
      discard_q  <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      discard_q  <= discard_d;
      misalign_q <= misalign_d;
    end
  end
endmodule

// File: tb/tb_mod_instr_fetch.sv
// Directed bench for mod_instr_fetch with a responsive imem model (configurable grant and response latency).
`ifndef XLEN
`define XLEN 32
`endif

module tb_mod_instr_fetch;
  logic             clk_i = 1'b0;
  logic             rst_i = 1'b1;
  logic             imem_req_o;
  logic [`XLEN-1:0] imem_addr_o;
  logic             imem_gnt_i = 1'b0;
  logic             imem_rvalid_i = 1'b0;
  logic [`XLEN-1:0] imem_rdata_i = '0;
  logic             redirect_i = 1'b0;
  logic [`XLEN-1:0] redirect_pc_i = '0;
  logic             instr_valid_o;
  logic             instr_ready_i = 1'b0;
  logic [`XLEN-1:0] instr_o;
  logic [`XLEN-1:0] instr_pc_o;
  logic             misalign_o;

  mod_instr_fetch #(.RESET_PC('0), .FIFO_DEPTH(2)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready_i),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o),
    .misalign_o    (misalign_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int lat   = 1;
  logic gnt_en = 1'b0;

  logic [31:0] pend_addr[$];
  int          pend_cyc[$];
  logic [31:0] req_log[$];
  logic [31:0] acc_pc[$];
  logic [31:0] acc_instr[$];
  int          acc_cyc[$];

  logic        obs_req, obs_vld, obs_mis;
  logic [31:0] obs_addr, obs_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic clear_logs();
    req_log.delete();
    acc_pc.delete();
    acc_instr.delete();
    acc_cyc.delete();
  endtask

  // Ends at a falling edge with reset released; the next tick is cycle 1 (S_BOOT).
  task automatic do_reset();
    rst_i = 1'b1;
    redirect_i = 1'b0;
    redirect_pc_i = '0;
    imem_gnt_i = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i = '0;
    instr_ready_i = 1'b0;
    pend_addr.delete();
    pend_cyc.delete();
    clear_logs();
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    cyc = 1;
  endtask

  // One clock cycle: drive inputs at the falling edge, observe, then cross the rising edge.
  task automatic tick(input logic redir, input logic [31:0] rpc);
    logic do_rsp;
    redirect_i    = redir;
    redirect_pc_i = rpc;
    imem_gnt_i    = gnt_en;
    do_rsp        = (pend_addr.size() > 0) && (cyc >= pend_cyc[0] + lat);
    imem_rvalid_i = do_rsp;
    imem_rdata_i  = do_rsp ? mem_word(pend_addr[0]) : 32'h0;
    #1;
    obs_req  = imem_req_o;
    obs_addr = imem_addr_o;
    obs_vld  = instr_valid_o;
    obs_pc   = instr_pc_o;
    obs_mis  = misalign_o;
    if (obs_req && imem_gnt_i) begin
      pend_addr.push_back(obs_addr);
      pend_cyc.push_back(cyc);
      req_log.push_back(obs_addr);
    end
    if (obs_vld && instr_ready_i) begin
      acc_pc.push_back(obs_pc);
      acc_instr.push_back(instr_o);
      acc_cyc.push_back(cyc);
    end
    if (do_rsp) begin
      void'(pend_addr.pop_front());
      void'(pend_cyc.pop_front());
    end
    @(posedge clk_i);
    cyc++;
    @(negedge clk_i);
  endtask

  task automatic test_reset();
    do_reset();
    gnt_en = 1'b1;
    lat = 1;
    repeat (4) tick(1'b0, 32'h0);
    #2 rst_i = 1'b1;
    #1;
    total++; if (imem_req_o !== 1'b0) begin bad++; $display("FAIL rst_req: got %b want 0", imem_req_o); end
    total++; if (imem_addr_o !== 32'h0) begin bad++; $display("FAIL rst_addr: got %h want 0", imem_addr_o); end
    total++; if (instr_valid_o !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", instr_valid_o); end
    total++; if (instr_o !== 32'h0) begin bad++; $display("FAIL rst_instr: got %h want 0", instr_o); end
    total++; if (instr_pc_o !== 32'h0) begin bad++; $display("FAIL rst_pc: got %h want 0", instr_pc_o); end
    total++; if (misalign_o !== 1'b0) begin bad++; $display("FAIL rst_misalign: got %b want 0", misalign_o); end
    do_reset();
    gnt_en = 1'b1;
    tick(1'b0, 32'h0);
    total++; if (obs_req !== 1'b0) begin bad++; $display("FAIL boot_no_req: got %b want 0", obs_req); end
    tick(1'b0, 32'h0);
    total++; if (obs_req !== 1'b1 || obs_addr !== 32'h0) begin bad++; $display("FAIL first_req: got req=%b addr=%h want req=1 addr=0", obs_req, obs_addr); end
  endtask

  task automatic test_stream();
    do_reset();
    gnt_en = 1'b1;
    lat = 1;
    instr_ready_i = 1'b1;
    repeat (12) tick(1'b0, 32'h0);
    total++; if (acc_cyc.size() < 6 || acc_cyc[0] !== 4) begin bad++; $display("FAIL stream_first: got n=%0d cyc=%0d want cyc=4", acc_cyc.size(), acc_cyc.size() > 0 ? acc_cyc[0] : -1); end
    total++; if (acc_cyc.size() < 6 || acc_cyc[5] !== acc_cyc[0] + 5) begin bad++; $display("FAIL stream_rate: got 6 words over %0d cycles want 6", acc_cyc.size() >= 6 ? acc_cyc[5] - acc_cyc[0] + 1 : -1); end
    for (int i = 0; i < 6; i++) begin
      logic [31:0] p;
      p = 32'(i * 4);
      total++; if (acc_pc.size() <= i || acc_pc[i] !== p || acc_instr[i] !== mem_word(p)) begin bad++; $display("FAIL stream_word%0d: got pc=%h instr=%h want pc=%h instr=%h", i, acc_pc.size() > i ? acc_pc[i] : 32'hx, acc_instr.size() > i ? acc_instr[i] : 32'hx, p, mem_word(p)); end
    end
  endtask

  task automatic test_stall();
    do_reset();
    gnt_en = 1'b1;
    lat = 1;
    instr_ready_i = 1'b0;
    repeat (8) tick(1'b0, 32'h0);
    total++; if (req_log.size() !== 2) begin bad++; $display("FAIL stall_reqs: got %0d want 2", req_log.size()); end
    total++; if (obs_req !== 1'b0) begin bad++; $display("FAIL stall_req_low: got %b want 0", obs_req); end
    total++; if (obs_vld !== 1'b1 || obs_pc !== 32'h0) begin bad++; $display("FAIL stall_head: got vld=%b pc=%h want vld=1 pc=0", obs_vld, obs_pc); end
    instr_ready_i = 1'b1;
    clear_logs();
    repeat (6) tick(1'b0, 32'h0);
    total++; if (acc_pc.size() < 3 || acc_pc[0] !== 32'h0 || acc_pc[1] !== 32'h4 || acc_pc[2] !== 32'h8) begin bad++; $display("FAIL stall_drain: got n=%0d pcs=%p want 0,4,8", acc_pc.size(), acc_pc); end
    total++; if (req_log.size() < 1 || req_log[0] !== 32'h8) begin bad++; $display("FAIL stall_resume: got %p want first 8", req_log); end
  endtask

  task automatic test_redirect_flush();
    do_reset();
    gnt_en = 1'b1;
    lat = 4;
    instr_ready_i = 1'b1;
    repeat (4) tick(1'b0, 32'h0);
    total++; if (pend_addr.size() !== 2) begin bad++; $display("FAIL flush_inflight: got %0d want 2", pend_addr.size()); end
    clear_logs();
    tick(1'b1, 32'h100);
    total++; if (obs_req !== 1'b0) begin bad++; $display("FAIL flush_req_gated: got %b want 0", obs_req); end
    repeat (14) tick(1'b0, 32'h0);
    total++; if (req_log.size() < 1 || req_log[0] !== 32'h100) begin bad++; $display("FAIL flush_newreq: got %p want first 100", req_log); end
    total++; if (acc_pc.size() < 2 || acc_pc[0] !== 32'h100 || acc_instr[0] !== mem_word(32'h100)) begin bad++; $display("FAIL flush_first: got pcs=%p want first 100", acc_pc); end
    total++; if (acc_pc.size() < 2 || acc_pc[1] !== 32'h104) begin bad++; $display("FAIL flush_second: got pcs=%p want second 104", acc_pc); end
  endtask

  task automatic test_redirect_collide();
    do_reset();
    gnt_en = 1'b1;
    lat = 1;
    instr_ready_i = 1'b1;
    repeat (6) tick(1'b0, 32'h0);
    tick(1'b1, 32'h300);
    clear_logs();
    tick(1'b0, 32'h0);
    total++; if (obs_vld !== 1'b0) begin bad++; $display("FAIL collide_cleared: got vld=%b want 0", obs_vld); end
    repeat (10) tick(1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      logic [31:0] p;
      p = 32'h300 + 32'(i * 4);
      total++; if (acc_pc.size() <= i || acc_pc[i] !== p || acc_instr[i] !== mem_word(p)) begin bad++; $display("FAIL collide_word%0d: got pcs=%p want %h", i, acc_pc, p); end
    end
    gnt_en = 1'b0;
    repeat (4) tick(1'b0, 32'h0);
    instr_ready_i = 1'b0;
    gnt_en = 1'b1;
    clear_logs();
    repeat (6) tick(1'b0, 32'h0);
    total++; if (req_log.size() !== 2) begin bad++; $display("FAIL collide_credits: got %0d reqs want 2", req_log.size()); end
  endtask

  task automatic test_pc_wrap();
    do_reset();
    gnt_en = 1'b1;
    lat = 1;
    instr_ready_i = 1'b1;
    repeat (3) tick(1'b0, 32'h0);
    tick(1'b1, 32'hFFFF_FFFC);
    clear_logs();
    repeat (8) tick(1'b0, 32'h0);
    total++; if (req_log.size() < 2 || req_log[0] !== 32'hFFFF_FFFC || req_log[1] !== 32'h0) begin bad++; $display("FAIL wrap_addr: got %p want fffffffc,0", req_log); end
    total++; if (acc_pc.size() < 2 || acc_pc[0] !== 32'hFFFF_FFFC || acc_pc[1] !== 32'h0) begin bad++; $display("FAIL wrap_instr: got %p want fffffffc,0", acc_pc); end
  endtask

  task automatic test_misalign();
    do_reset();
    gnt_en = 1'b1;
    lat = 1;
    instr_ready_i = 1'b1;
    repeat (3) tick(1'b0, 32'h0);
    tick(1'b1, 32'h102);
    clear_logs();
    repeat (6) tick(1'b0, 32'h0);
`ifdef FETCH_MISALIGN_TRAP_EN
    total++; if (obs_mis !== 1'b1) begin bad++; $display("FAIL trap_flag: got %b want 1", obs_mis); end
    total++; if (req_log.size() !== 0 || acc_pc.size() !== 0) begin bad++; $display("FAIL trap_quiet: got reqs=%0d words=%0d want 0,0", req_log.size(), acc_pc.size()); end
    tick(1'b1, 32'h200);
    clear_logs();
    repeat (6) tick(1'b0, 32'h0);
    total++; if (obs_mis !== 1'b0) begin bad++; $display("FAIL trap_clear: got %b want 0", obs_mis); end
    total++; if (req_log.size() < 1 || req_log[0] !== 32'h200 || acc_pc.size() < 1 || acc_pc[0] !== 32'h200) begin bad++; $display("FAIL trap_resume: got reqs=%p words=%p want 200", req_log, acc_pc); end
`else
    total++; if (obs_mis !== 1'b0) begin bad++; $display("FAIL misalign_off: got %b want 0", obs_mis); end
    total++; if (req_log.size() < 1 || req_log[0] !== 32'h100 || acc_pc.size() < 1 || acc_pc[0] !== 32'h100) begin bad++; $display("FAIL misalign_ignored: got reqs=%p words=%p want 100", req_log, acc_pc); end
`endif
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_flush();
    test_redirect_collide();
    test_pc_wrap();
    test_misalign();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
